store_buffer: RTL

//  In-order FIFO of committed stores that sits directly upstream of the data cache's write port.
//  The cache stage pushes each store here once it is accepted; the head entry drives the cache

---
 rtl/store_buffer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order FIFO of committed stores that sits directly in front of the data
// cache write port. The cache stage pushes each accepted store at the tail.
// The head entry drives the cache write port until the cache acknowledges it
// with store_success, and then it is popped. Loads probe every live entry for
// store-to-load forwarding. A load that is only partly covered by a buffered
// store stalls and must retry.
//
// Parameters
//   SB_ENTRIES        FIFO depth (power of two, >= 2)
//   WORD_SIZE         address / data width
//   SIZE_WRITE_WIDTH  width of the access size code
//   BYTE_SIZE         size code of a byte access
//   FULL_WORD_SIZE    size code of a full-word access
//
// Ports
//   clk, rst                         clock (rising edge), async active-high reset
//   push, push_addr/value/size       enqueue a store (ignored while full)
//   full, empty, count               occupancy status
//   wenable, sb_addr/value/size      head entry, presented as a cache write request
//   store_success                    cache wrote the head this cycle -> pop
//   ld_valid, ld_addr, ld_size       load probe
//   fwd_hit, fwd_data, fwd_stall     forwarding result (byte data sign-extended)
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int SB_ENTRIES       = 4,
    parameter int WORD_SIZE        = 32,
    parameter int SIZE_WRITE_WIDTH = 2,
    parameter logic [SIZE_WRITE_WIDTH-1:0] BYTE_SIZE      = 'd0,
    parameter logic [SIZE_WRITE_WIDTH-1:0] FULL_WORD_SIZE = 'd2
) (
    input  logic                          clk,
    input  logic                          rst,
    // Enqueue side
    input  logic                          push,
    input  logic [WORD_SIZE-1:0]          push_addr,
    input  logic [WORD_SIZE-1:0]          push_value,
    input  logic [SIZE_WRITE_WIDTH-1:0]   push_size,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(SB_ENTRIES):0]   count,
    // Cache write port (head entry)
    output logic                          wenable,
    output logic [WORD_SIZE-1:0]          sb_addr,
    output logic [WORD_SIZE-1:0]          sb_value,
    output logic [SIZE_WRITE_WIDTH-1:0]   sb_size,
    input  logic                          store_success,
    // Load forwarding probe
    input  logic                          ld_valid,
    input  logic [WORD_SIZE-1:0]          ld_addr,
    input  logic [SIZE_WRITE_WIDTH-1:0]   ld_size,
    output logic                          fwd_hit,
    output logic [WORD_SIZE-1:0]          fwd_data,
    output logic                          fwd_stall
);

    localparam int PTR_W = $clog2(SB_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Sign-extend a byte to the full data width.
    function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] b);
        return {{(WORD_SIZE-8){b[7]}}, b};
    endfunction

    // Pick byte lane 'sel' out of a word (little-endian lane numbering).
    function automatic logic [7:0] byte_lane(input logic [WORD_SIZE-1:0] w,
                                             input logic [1:0]           sel);
        logic [WORD_SIZE-1:0] sh;
        sh = w >> {sel, 3'b000};
        return sh[7:0];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------

    // Control state: reset asynchronously.
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SB_ENTRIES-1:0] valid_q, valid_d;

    // Entry payload: no reset needed, every read is qualified by valid_q/empty.
    logic [WORD_SIZE-1:0]        addr_q  [SB_ENTRIES];
    logic [WORD_SIZE-1:0]        value_q [SB_ENTRIES];
    logic [SIZE_WRITE_WIDTH-1:0] size_q  [SB_ENTRIES];

    logic push_ok;
    logic pop_ok;

    // -------------------------------------------------------------------------
    // Status and head outputs
    // -------------------------------------------------------------------------

    // Full/empty come from registered state only, so a push cannot be accepted
    // on the strength of a same-cycle pop.
    assign full    = (count_q == CNT_W'(SB_ENTRIES));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign wenable = !empty;

    assign sb_addr  = empty ? '0 : addr_q[head_q];
    assign sb_value = empty ? '0 : value_q[head_q];
    assign sb_size  = empty ? '0 : size_q[head_q];

    assign push_ok = push && !full;
    assign pop_ok  = wenable && store_success;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;

        // Pop is applied before push. A push can only share a slot with the
        // head when the buffer is empty, and then there is no pop.
        if (pop_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push_ok) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[tail_q]  <= push_addr;
            value_q[tail_q] <= push_value;
            size_q[tail_q]  <= push_size;
        end
    end

    // -------------------------------------------------------------------------
    // Store-to-load forwarding
    // -------------------------------------------------------------------------
    // Entries are walked from oldest (head) to youngest. Every relevant match
    // overwrites the result, so the youngest relevant entry decides. A byte
    // entry covering a different byte of the loaded byte's word is not
    // relevant and leaves the older result in place.
    logic [PTR_W-1:0] idx;
    logic             ld_is_byte;
    logic             ent_is_byte;

    always_comb begin
        fwd_hit     = 1'b0;
        fwd_stall   = 1'b0;
        fwd_data    = '0;
        idx         = head_q;
        ent_is_byte = 1'b0;
        ld_is_byte  = (ld_size == BYTE_SIZE);

        if (ld_valid) begin
            for (int k = 0; k < SB_ENTRIES; k++) begin
                idx         = head_q + PTR_W'(k);
                ent_is_byte = (size_q[idx] == BYTE_SIZE);
                if (valid_q[idx] &&
                    (addr_q[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2])) begin
                    if (!ld_is_byte && ent_is_byte) begin
                        // Word load only partly covered by a byte store.
                        fwd_hit   = 1'b0;
                        fwd_stall = 1'b1;
                        fwd_data  = '0;
                    end else if (!ld_is_byte) begin
                        fwd_hit   = 1'b1;
                        fwd_stall = 1'b0;
                        fwd_data  = value_q[idx];
                    end else if (!ent_is_byte) begin
                        fwd_hit   = 1'b1;
                        fwd_stall = 1'b0;
                        fwd_data  = sext8(byte_lane(value_q[idx], ld_addr[1:0]));
                    end else if (addr_q[idx][1:0] == ld_addr[1:0]) begin
                        fwd_hit   = 1'b1;
                        fwd_stall = 1'b0;
                        fwd_data  = sext8(value_q[idx][7:0]);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Checks
    // -------------------------------------------------------------------------
    // Word stores must be word-aligned.
    a_word_aligned: assert property (@(posedge clk) disable iff (rst)
        (push && !full && (push_size == FULL_WORD_SIZE)) |-> (push_addr[1:0] == 2'b00));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(SB_ENTRIES));

endmodule
